// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path of the serial-to-SPI bridge.
// Contents: frame state encoding, default clock/baud constants, parity helper.
// Optional feature macro used by importers: UART_TX_PARITY_EN (even parity bit).
package uart_pkg;

    localparam int CLK_HZ        = 50_000_000;
    localparam int BAUD_DIV_9600 = 5208;        // CLK_HZ / 9600, rounded down

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period counter: counts 0..DIV-1 and pulses tick_o for one cycle on the
// last count of each bit, i.e. on the bit boundary; counter wraps to 0 there.
// Ports: clk_50/rst_n (sync, active-low), clr_i holds the count at 0, tick_o.
module baud_gen
    import uart_pkg::*;
#(
    parameter int DIV = BAUD_DIV_9600,
    parameter int W   = 13
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        tick_o = !clr_i && (cnt_q == LAST);
        cnt_d  = cnt_q + W'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 (optionally 8E1) with a one-byte holding register so
// the next byte can be queued during a frame and sent with no idle gap.
// Ports: clk_50, rst_n (sync, active-low), DATA_IN/DATA_VALID/DATA_READY
// handshake, TX serial line (idle high, registered), BUSY (state != IDLE).
// Macro: UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_9600,
    parameter int CNT_W    = 13
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic [7:0] DATA_IN,
    input  logic       DATA_VALID,
    output logic       DATA_READY,
    output logic       TX,
    output logic       BUSY
);

    uart_state_e state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        tx_q, tx_d;
    logic        tick;

    // Counter is parked at 0 while idle so every bit starts a full period.
    baud_gen #(
        .DIV (BAUD_DIV),
        .W   (CNT_W)
    ) u_baud_gen (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = 1'b1;

        // Accept and transfer are mutually exclusive: one needs the holding
        // register empty, the other needs it full.
        if (DATA_VALID && !hold_full_q) begin
            hold_d      = DATA_IN;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    idx_d       = 3'd0;
                    state_d     = START;
                end
            end
            START: begin
                if (tick) begin
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    // Queued byte goes straight into a start bit: no idle bit.
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        idx_d       = 3'd0;
                        state_d     = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // TX is decoded from the next state so the registered line changes on
        // the same edge as the state, keeping TX and BUSY aligned.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[idx_d];
            PARITY:  tx_d = even_parity(shift_d);
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
        end
    end

    assign DATA_READY = !hold_full_q;
    assign TX         = tx_q;
    assign BUSY       = (state_q != IDLE);

endmodule
